// File: rtl/minx_bus_pkg.sv
// Shared definitions for the MINX bus arbiter: arbiter states, bus status
// codes and the default on-chip register window.
package minx_bus_pkg;

  // Arbiter sequencing: CPU owns the bus, CPU asked to let go, a DMA master
  // owns the bus, and bus being handed back while the CPU drops its ack.
  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    REQ_CPU = 2'd1,
    GRANTED = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Bus status codes carried on m_status / bus_status.
  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] BUS_OTHER = 2'b11;

  // Default inclusive window decoded as on-chip registers.
  localparam logic [23:0] REG_BASE_DEFAULT = 24'h002000;
  localparam logic [23:0] REG_LAST_DEFAULT = 24'h0020FF;

endpackage

// File: rtl/minx_arb_pick.sv
// Winner selection among DMA masters 1..N-1. Fixed mode returns the lowest
// requesting index; round-robin mode returns the first requester at or above
// ptr, wrapping back to the lowest requester when none is found above it.
module minx_arb_pick
  import minx_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  localparam int IDX_W = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-2:0] req,
  input  logic [IDX_W-1:0]       ptr,
  input  logic                   rr_mode,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  logic [IDX_W-1:0] lo_idx;
  logic             lo_hit;
  logic [IDX_W-1:0] hi_idx;
  logic             hi_hit;

  // Scan downward so the last hit is the lowest index; track the lowest
  // requester overall and the lowest requester at or above the pointer.
  always_comb begin
    lo_idx = '0;
    lo_hit = 1'b0;
    hi_idx = '0;
    hi_hit = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 1; i--) begin
      if (req[i-1]) begin
        lo_idx = IDX_W'(i);
        lo_hit = 1'b1;
        if (IDX_W'(i) >= ptr) begin
          hi_idx = IDX_W'(i);
          hi_hit = 1'b1;
        end
      end
    end
    idx   = (rr_mode && hi_hit) ? hi_idx : lo_idx;
    valid = lo_hit;
  end

endmodule

// File: rtl/minx_bus_arbiter.sv
// MINX bus arbiter: the CPU (master 0) owns the bus by default; DMA masters
// obtain it through a request/ack handshake with the CPU, and the selected
// owner's bus signals are muxed onto the shared bus.
module minx_bus_arbiter
  import minx_bus_pkg::*;
#(
  parameter int                NUM_MASTERS = 3,
  parameter int                ADDR_W      = 24,
  parameter int                DATA_W      = 8,
  parameter int                RR_MODE     = 0,
  parameter logic [ADDR_W-1:0] REG_BASE    = ADDR_W'(REG_BASE_DEFAULT),
  parameter logic [ADDR_W-1:0] REG_LAST    = ADDR_W'(REG_LAST_DEFAULT),
  parameter int                MAX_HOLD    = 1024,
  localparam int               IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-2:0]        dma_req,
  output logic [NUM_MASTERS-2:0]        dma_grant,
  output logic                          cpu_bus_request,
  input  logic                          cpu_bus_ack,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*2-1:0]      m_status,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [DATA_W-1:0]             bus_wdata,
  output logic                          bus_read,
  output logic                          bus_write,
  output logic [1:0]                    bus_status,
  input  logic [DATA_W-1:0]             ext_rdata,
  input  logic [DATA_W-1:0]             reg_rdata,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [IDX_W-1:0]              owner,
  output logic                          hold_timeout
);

  // Hold counter counts completed grant cycles; the flag is armed one cycle
  // early so that it is visible during the MAX_HOLD-th cycle of a grant.
  localparam int               HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_TRIP = HOLD_W'(MAX_HOLD - 2);

  arb_state_e              state_q, state_d;
  logic [NUM_MASTERS-2:0]  grant_q, grant_d;
  logic                    cpu_req_q, cpu_req_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    timeout_q, timeout_d;

  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic [NUM_MASTERS-2:0]  win_onehot;
  logic [IDX_W-1:0]        ptr_after_win;
  logic                    any_req;
  logic                    owner_req;
  logic                    latch_win;

  logic [ADDR_W-1:0]       addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0]       wdata_arr [NUM_MASTERS];
  logic [1:0]              status_arr[NUM_MASTERS];
  logic                    in_reg_win;

  minx_arb_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .req     (dma_req),
    .ptr     (ptr_q),
    .rr_mode (RR_MODE != 0),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  // Unpack the flattened per-master buses and build the winner's one-hot grant.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign addr_arr[gi]   = m_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi]  = m_wdata[gi*DATA_W +: DATA_W];
    assign status_arr[gi] = m_status[gi*2 +: 2];
  end

  for (genvar gi = 0; gi < NUM_MASTERS - 1; gi++) begin : g_onehot
    assign win_onehot[gi] = (pick_idx == IDX_W'(gi + 1));
  end

  assign any_req       = |dma_req;
  assign owner_req     = |(dma_req & grant_q);
  assign ptr_after_win = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? IDX_W'(1)
                                                               : pick_idx + IDX_W'(1);

  // Next-state logic for the handshake sequencer, grant, pointer and hold timer.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cpu_req_d = cpu_req_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;
    latch_win = 1'b0;

    case (state_q)
      CPU_OWN: begin
        if (any_req) begin
          state_d   = REQ_CPU;
          cpu_req_d = 1'b1;
        end
      end
      REQ_CPU: begin
        // Requests vanishing before the ack abort the hand-over.
        if (!any_req) begin
          state_d   = RELEASE;
          cpu_req_d = 1'b0;
        end else if (cpu_bus_ack && pick_valid) begin
          latch_win = 1'b1;
        end
      end
      GRANTED: begin
        // No preemption: the owner keeps the bus while it keeps requesting;
        // the CPU ack is deliberately not looked at here.
        if (owner_req) begin
          if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + HOLD_W'(1);
          end
          if (hold_q >= HOLD_TRIP) begin
            timeout_d = 1'b1;
          end
        end else if (pick_valid) begin
          latch_win = 1'b1;
        end else begin
          state_d   = RELEASE;
          grant_d   = '0;
          owner_d   = '0;
          cpu_req_d = 1'b0;
        end
      end
      RELEASE: begin
        if (!cpu_bus_ack) begin
          state_d = CPU_OWN;
        end
      end
      default: begin
        state_d   = CPU_OWN;
        grant_d   = '0;
        owner_d   = '0;
        cpu_req_d = 1'b0;
      end
    endcase

    if (latch_win) begin
      state_d = GRANTED;
      grant_d = win_onehot;
      owner_d = pick_idx;
      ptr_d   = ptr_after_win;
      hold_d  = '0;
    end
  end

  // State and registered outputs; reset hands the bus straight back to the CPU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CPU_OWN;
      grant_q   <= '0;
      cpu_req_q <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= IDX_W'(1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cpu_req_q <= cpu_req_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Shared bus follows the owner; reads inside the register window return
  // on-chip register data, everything else returns external memory data.
  always_comb begin
    bus_addr   = addr_arr[owner_q];
    bus_wdata  = wdata_arr[owner_q];
    bus_read   = m_read[owner_q];
    bus_write  = m_write[owner_q];
    bus_status = status_arr[owner_q];
    in_reg_win = (bus_addr >= REG_BASE) && (bus_addr <= REG_LAST);
    m_rdata    = (bus_read && (bus_status == MEM_READ) && in_reg_win) ? reg_rdata
                                                                       : ext_rdata;
  end

  assign dma_grant       = grant_q;
  assign cpu_bus_request = cpu_req_q;
  assign owner           = owner_q;
  assign hold_timeout    = timeout_q;

endmodule

// File: tb/tb_minx_bus_arbiter.sv
// Bench for minx_bus_arbiter: a fixed-priority and a round-robin instance
// share one stimulus stream and are each compared every cycle against a
// rule-level reference model, plus directed hand-over scenarios.
module tb_minx_bus_arbiter;

  localparam int NM   = 3;
  localparam int AW   = 24;
  localparam int DW   = 8;
  localparam int HOLD = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM-2:0]     dma_req;
  logic              cpu_bus_ack;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_read, m_write;
  logic [NM*2-1:0]   m_status;
  logic [DW-1:0]     ext_rdata, reg_rdata;

  logic [NM-2:0] f_grant, r_grant;
  logic          f_req, r_req;
  logic [AW-1:0] f_baddr, r_baddr;
  logic [DW-1:0] f_bwdata, r_bwdata, f_rdata, r_rdata;
  logic          f_bread, r_bread, f_bwrite, r_bwrite;
  logic [1:0]    f_bstat, r_bstat, f_owner, r_owner;
  logic          f_to, r_to;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state, index 0 = fixed mode, 1 = round-robin.
  int md_owner[2];
  bit md_ask[2];
  bit md_drain[2];
  bit md_to[2];
  int md_ptr[2];
  int md_held[2];

  always #5 clk = ~clk;

  minx_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_HOLD(HOLD)) u_fix (
    .clk(clk), .rst_n(rst_n), .dma_req(dma_req), .dma_grant(f_grant),
    .cpu_bus_request(f_req), .cpu_bus_ack(cpu_bus_ack),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write), .m_status(m_status),
    .bus_addr(f_baddr), .bus_wdata(f_bwdata), .bus_read(f_bread), .bus_write(f_bwrite),
    .bus_status(f_bstat), .ext_rdata(ext_rdata), .reg_rdata(reg_rdata), .m_rdata(f_rdata),
    .owner(f_owner), .hold_timeout(f_to));

  minx_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_HOLD(HOLD)) u_rr (
    .clk(clk), .rst_n(rst_n), .dma_req(dma_req), .dma_grant(r_grant),
    .cpu_bus_request(r_req), .cpu_bus_ack(cpu_bus_ack),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write), .m_status(m_status),
    .bus_addr(r_baddr), .bus_wdata(r_bwdata), .bus_read(r_bread), .bus_write(r_bwrite),
    .bus_status(r_bstat), .ext_rdata(ext_rdata), .reg_rdata(reg_rdata), .m_rdata(r_rdata),
    .owner(r_owner), .hold_timeout(r_to));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int md);
    md_owner[md] = 0;
    md_ask[md]   = 0;
    md_drain[md] = 0;
    md_to[md]    = 0;
    md_ptr[md]   = 1;
    md_held[md]  = 0;
  endtask

  // First requester found when scanning masters 1..N-1 from the start point.
  function automatic int pick(input int md, input logic [NM-2:0] rq);
    int base;
    int i;
    base = (md == 1) ? md_ptr[1] : 1;
    for (int k = 0; k < NM - 1; k++) begin
      i = ((base - 1 + k) % (NM - 1)) + 1;
      if (rq[i-1]) return i;
    end
    return 0;
  endfunction

  task automatic win(input int md, input logic [NM-2:0] rq);
    int w;
    w = pick(md, rq);
    md_owner[md] = w;
    md_held[md]  = 1;
    md_ptr[md]   = (w % (NM - 1)) + 1;
    $display("grant mode=%0d master=%0d cycle=%0d", md, w, cyc);
  endtask

  task automatic model_step(input int md);
    logic [NM-2:0] rq;
    rq = dma_req;
    if (md_drain[md]) begin
      if (!cpu_bus_ack) md_drain[md] = 0;
    end else if (md_owner[md] != 0) begin
      if (rq[md_owner[md]-1]) begin
        md_held[md]++;
        if (md_held[md] >= HOLD) md_to[md] = 1;
      end else if (rq != 0) begin
        win(md, rq);
      end else begin
        md_owner[md] = 0;
        md_ask[md]   = 0;
        md_drain[md] = 1;
      end
    end else if (md_ask[md]) begin
      if (rq == 0) begin
        md_ask[md]   = 0;
        md_drain[md] = 1;
      end else if (cpu_bus_ack) begin
        win(md, rq);
      end
    end else if (rq != 0) begin
      md_ask[md] = 1;
    end
  endtask

  task automatic check_dut(input int md, input logic [NM-2:0] g, input logic rq,
                           input logic [1:0] ow, input logic to, input logic [AW-1:0] ba,
                           input logic [DW-1:0] bw, input logic br, input logic bwr,
                           input logic [1:0] bs, input logic [DW-1:0] rd);
    int o;
    logic [NM-2:0] eg;
    logic [AW-1:0] ea;
    logic [1:0]    es;
    logic [DW-1:0] erd;
    o  = md_owner[md];
    eg = (o == 0) ? '0 : (NM-1)'(1) << (o - 1);
    ea = m_addr[o*AW +: AW];
    es = m_status[o*2 +: 2];
    erd = (m_read[o] && es == 2'b01 && ea >= 24'h002000 && ea <= 24'h0020FF) ? reg_rdata : ext_rdata;
    chk($sformatf("grant%0d", md), g, eg);
    chk($sformatf("cpureq%0d", md), rq, md_ask[md]);
    chk($sformatf("owner%0d", md), ow, o);
    chk($sformatf("timeout%0d", md), to, md_to[md]);
    chk($sformatf("baddr%0d", md), ba, ea);
    chk($sformatf("bwdata%0d", md), bw, m_wdata[o*DW +: DW]);
    chk($sformatf("brd%0d", md), br, m_read[o]);
    chk($sformatf("bwr%0d", md), bwr, m_write[o]);
    chk($sformatf("bstat%0d", md), bs, es);
    chk($sformatf("rdata%0d", md), rd, erd);
  endtask

  task automatic check_both();
    check_dut(0, f_grant, f_req, f_owner, f_to, f_baddr, f_bwdata, f_bread, f_bwrite, f_bstat, f_rdata);
    check_dut(1, r_grant, r_req, r_owner, r_to, r_baddr, r_bwdata, r_bread, r_bwrite, r_bstat, r_rdata);
  endtask

  // One clock: model follows the edge, outputs are compared at the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    for (int md = 0; md < 2; md++) begin
      if (rst_n) model_step(md);
      else model_reset(md);
    end
    @(negedge clk);
    check_both();
  endtask

  task automatic drive_random();
    logic [AW-1:0] a;
    for (int b = 0; b < NM - 1; b++)
      if ($urandom_range(0, 5) == 0) dma_req[b] = ~dma_req[b];
    if ($urandom_range(0, 2) == 0) cpu_bus_ack = ~cpu_bus_ack;
    for (int m = 0; m < NM; m++) begin
      case ($urandom_range(0, 5))
        0: a = 24'h002000;
        1: a = 24'h0020FF;
        2: a = 24'h002080;
        3: a = 24'h002100;
        4: a = 24'h001FFF;
        default: a = AW'($urandom);
      endcase
      m_addr[m*AW +: AW]  = a;
      m_wdata[m*DW +: DW] = DW'($urandom);
      m_status[m*2 +: 2]  = 2'($urandom);
      m_read[m]           = 1'($urandom);
      m_write[m]          = 1'($urandom);
    end
    ext_rdata = DW'($urandom);
    reg_rdata = DW'($urandom);
  endtask

  int rr_seq[4];
  int seen, cnt, last;

  initial begin
    rst_n = 1'b0;
    dma_req = '0; cpu_bus_ack = 1'b0;
    m_addr = '0; m_wdata = '0; m_read = '0; m_write = '0; m_status = '0;
    ext_rdata = 8'h5A; reg_rdata = 8'hA5;
    model_reset(0); model_reset(1);
    #2;
    check_both();
    chk("rst_grant", f_grant, 0);
    chk("rst_req", f_req, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single-master hand-over: request, three cycles of waiting, ack.
    for (int c = 1; c <= 4; c++) step();
    dma_req = 2'b01;
    step();
    chk("req_rise", f_req, 1);
    chk("no_grant_before_ack", f_grant, 0);
    step(); step();
    chk("req_held", f_req, 1);
    cpu_bus_ack = 1'b1;
    step();
    chk("grant_m1", f_grant, 2'b01);
    chk("owner_m1", f_owner, 1);
    chk("to_early", f_to, 0);

    // Long grant with register-window reads and an ignored ack drop.
    for (int c = 2; c <= 20; c++) begin
      if (c == 5) begin
        m_addr[1*AW +: AW] = 24'h002080; m_read[1] = 1'b1; m_status[3:2] = 2'b01;
      end
      if (c == 6) m_addr[1*AW +: AW] = 24'h002100;
      if (c == 8) cpu_bus_ack = 1'b0;
      step();
      if (c == 5) chk("rdata_reg", f_rdata, 8'hA5);
      if (c == 6) chk("rdata_ext", f_rdata, 8'h5A);
      if (c == 15) chk("to_cycle15", f_to, 0);
      if (c == 16) chk("to_cycle16", f_to, 1);
    end
    chk("ack_drop_ignored", f_grant, 2'b01);

    // Second requester waits, then takes over without a CPU release.
    dma_req = 2'b11;
    step();
    chk("no_preempt", f_grant, 2'b01);
    dma_req = 2'b10;
    step();
    chk("regrant_m2", f_grant, 2'b10);
    chk("cpureq_kept", f_req, 1);
    chk("owner_m2", f_owner, 2);

    // Release, sticky timeout, request ignored while draining.
    cpu_bus_ack = 1'b1;
    dma_req = 2'b00;
    step();
    chk("release_grant", f_grant, 0);
    chk("release_req", f_req, 0);
    chk("to_sticky", f_to, 1);
    cpu_bus_ack = 1'b0;
    dma_req = 2'b01;
    step();
    chk("req_ignored_release", f_req, 0);
    step();
    chk("req_again", f_req, 1);
    cpu_bus_ack = 1'b1;
    step();
    chk("grant_again", f_grant, 2'b01);

    // Asynchronous reset during a grant.
    rst_n = 1'b0;
    #1;
    chk("arst_grant", f_grant, 0);
    chk("arst_owner", f_owner, 0);
    chk("arst_req", r_req, 0);
    chk("arst_to", f_to, 0);
    model_reset(0); model_reset(1);
    step();
    rst_n = 1'b1;

    // Round-robin alternation: each owner drops after 4 grant cycles.
    dma_req = 2'b11;
    cpu_bus_ack = 1'b1;
    seen = 0; cnt = 0; last = 0;
    for (int c = 0; c < 80 && seen < 4; c++) begin
      step();
      if (r_owner != 0) begin
        if (int'(r_owner) == last) cnt++;
        else begin
          cnt = 1; last = int'(r_owner); dma_req = 2'b11;
        end
        if (cnt == 4) begin
          rr_seq[seen] = int'(r_owner);
          seen++;
          dma_req[int'(r_owner) - 1] = 1'b0;
        end
      end
    end
    chk("rr_seen", seen, 4);
    for (int k = 0; k < seen; k++)
      chk($sformatf("rr_seq%0d", k), rr_seq[k], (k % 2 == 0) ? 1 : 2);

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rnd_arst_grant", {f_grant, r_grant}, 0);
        model_reset(0); model_reset(1);
        step();
        rst_n = 1'b1;
      end
      drive_random();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
